// File: rtl/cnn_pool_pkg.sv
// Shared definitions for the spatial pooling / broadcast stream blocks.
// Channel k of a flat vector lives at bits [(k+1)*DATA_W-1 : k*DATA_W].
package cnn_pool_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b01,
        S_EMIT = 2'b10
    } gbu_state_e;

    function automatic int unsigned pixel_count(input int unsigned h, input int unsigned w);
        return h * w;
    endfunction

    // Index width that never collapses to zero bits for a 1-deep dimension.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned data_w);
        return ch * data_w;
    endfunction

endpackage

// File: rtl/global_broadcast_unit_if.sv
// Vector-in / pixel-out stream bundle of the global broadcast unit.
interface global_broadcast_unit_if
    import cnn_pool_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IN_CH  = 8,
    parameter int unsigned IMG_H  = 4,
    parameter int unsigned IMG_W  = 5
);
    localparam int unsigned VW = IN_CH * DATA_W;
    localparam int unsigned RW = clog2_min1(IMG_H);
    localparam int unsigned CW = clog2_min1(IMG_W);

    logic          i_valid;
    logic          i_ready;
    logic [VW-1:0] i_data_flat;
    logic          o_valid;
    logic          o_ready;
    logic [VW-1:0] o_data_flat;
    logic [RW-1:0] o_row;
    logic [CW-1:0] o_col;
    logic          o_last;

    modport slave (
        input  i_valid, i_data_flat, o_ready,
        output i_ready, o_valid, o_data_flat, o_row, o_col, o_last
    );

    modport master (
        output i_valid, i_data_flat, o_ready,
        input  i_ready, o_valid, o_data_flat, o_row, o_col, o_last
    );
endinterface

// File: rtl/raster_counter.sv
// Row-major (row, col) walker over an IMG_H x IMG_W raster with a last-pixel flag.
module raster_counter
    import cnn_pool_pkg::*;
#(
    parameter int unsigned IMG_H = 4,
    parameter int unsigned IMG_W = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          step,
    output logic [clog2_min1(IMG_H)-1:0]  row,
    output logic [clog2_min1(IMG_W)-1:0]  col,
    output logic                          last
);
    localparam int unsigned RW = clog2_min1(IMG_H);
    localparam int unsigned CW = clog2_min1(IMG_W);
    localparam int unsigned PC = pixel_count(IMG_H, IMG_W);

    logic [RW-1:0] r_row, w_row_nxt;
    logic [CW-1:0] r_col, w_col_nxt;
    logic          r_last;

    // Next raster position when not on the final pixel.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col + CW'(1);
        if (r_col == CW'(IMG_W - 1)) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_last <= 1'b0;
        end else if (load) begin
            r_row  <= '0;
            r_col  <= '0;
            r_last <= (PC == 1);
        end else if (step) begin
            if (r_last) begin
                r_row  <= '0;
                r_col  <= '0;
                r_last <= 1'b0;
            end else begin
                r_row  <= w_row_nxt;
                r_col  <= w_col_nxt;
                r_last <= (w_row_nxt == RW'(IMG_H - 1)) && (w_col_nxt == CW'(IMG_W - 1));
            end
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign last = r_last;
endmodule

// File: rtl/global_broadcast_unit.sv
// Holds one channel vector and replays it as an IMG_H x IMG_W pixel raster.
module global_broadcast_unit
    import cnn_pool_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IN_CH  = 8,
    parameter int unsigned IMG_H  = 4,
    parameter int unsigned IMG_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    global_broadcast_unit_if.slave  bus
);
    localparam int unsigned VW = IN_CH * DATA_W;
    localparam int unsigned RW = clog2_min1(IMG_H);
    localparam int unsigned CW = clog2_min1(IMG_W);

    gbu_state_e    r_state, w_state_nxt;
    logic          r_valid, w_valid_nxt;
    logic [VW-1:0] r_data,  w_data_nxt;
    logic          w_load, w_step, w_beat, w_accept, w_i_ready;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic          w_last;

    raster_counter #(
        .IMG_H (IMG_H),
        .IMG_W (IMG_W)
    ) u_raster (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .step (w_step),
        .row  (w_row),
        .col  (w_col),
        .last (w_last)
    );

    // Ready on the last beat's handshake lets the next vector follow with no bubble.
    assign w_beat    = r_valid && bus.o_ready;
    assign w_i_ready = (r_state == S_IDLE) || ((r_state == S_EMIT) && w_last && bus.o_ready);
    assign w_accept  = bus.i_valid && w_i_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_data_nxt  = bus.i_data_flat;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_beat) begin
                    if (!w_last) begin
                        w_step = 1'b1;
                    end else if (w_accept) begin
                        w_load     = 1'b1;
                        w_data_nxt = bus.i_data_flat;
                    end else begin
                        w_step      = 1'b1;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign bus.i_ready     = w_i_ready;
    assign bus.o_valid     = r_valid;
    assign bus.o_data_flat = r_data;
    assign bus.o_row       = w_row;
    assign bus.o_col       = w_col;
    assign bus.o_last      = w_last;
endmodule

// File: tb/tb_global_broadcast_unit.sv
// Bench for global_broadcast_unit: a 4x5 instance and a 1x1 instance against a raster model.
module tb_global_broadcast_unit;
    import cnn_pool_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned CH = 8;
    localparam int unsigned VW = DW * CH;
    localparam int unsigned H0 = 4;
    localparam int unsigned W0 = 5;
    localparam int unsigned H1 = 1;
    localparam int unsigned W1 = 1;

    int img_w [2] = '{int'(W0), int'(W1)};
    int npix  [2] = '{int'(H0 * W0), int'(H1 * W1)};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic          iv   [2];
    logic [VW-1:0] idat [2];
    logic          ordy [2];

    logic          ob_ir   [2];
    logic          ob_ov   [2];
    logic          ob_last [2];
    logic [VW-1:0] ob_dat  [2];
    logic [31:0]   ob_row  [2];
    logic [31:0]   ob_col  [2];

    global_broadcast_unit_if #(.DATA_W(DW), .IN_CH(CH), .IMG_H(H0), .IMG_W(W0)) bus0 ();
    global_broadcast_unit_if #(.DATA_W(DW), .IN_CH(CH), .IMG_H(H1), .IMG_W(W1)) bus1 ();

    assign bus0.i_valid     = iv[0];
    assign bus0.i_data_flat = idat[0];
    assign bus0.o_ready     = ordy[0];
    assign bus1.i_valid     = iv[1];
    assign bus1.i_data_flat = idat[1];
    assign bus1.o_ready     = ordy[1];

    assign ob_ir[0]   = bus0.i_ready;
    assign ob_ov[0]   = bus0.o_valid;
    assign ob_last[0] = bus0.o_last;
    assign ob_dat[0]  = bus0.o_data_flat;
    assign ob_row[0]  = 32'(bus0.o_row);
    assign ob_col[0]  = 32'(bus0.o_col);
    assign ob_ir[1]   = bus1.i_ready;
    assign ob_ov[1]   = bus1.o_valid;
    assign ob_last[1] = bus1.o_last;
    assign ob_dat[1]  = bus1.o_data_flat;
    assign ob_row[1]  = 32'(bus1.o_row);
    assign ob_col[1]  = 32'(bus1.o_col);

    global_broadcast_unit #(.DATA_W(DW), .IN_CH(CH), .IMG_H(H0), .IMG_W(W0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    global_broadcast_unit #(.DATA_W(DW), .IN_CH(CH), .IMG_H(H1), .IMG_W(W1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Model: whether a vector is held, which pixel of the raster is being shown.
    bit            m_held  [2];
    int            m_k     [2];
    logic [VW-1:0] m_vec   [2];
    bit            m_fresh [2];
    bit            m_pend  [2];
    int            m_beats [2];
    int            m_accs  [2];
    bit            cont1;
    int            n_checks;
    int            n_fail;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ir(input int d);
        return !m_held[d] || ((m_k[d] == npix[d] - 1) && (ordy[d] === 1'b1));
    endfunction

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            string p;
            p = (d == 0) ? "u4x5" : "u1x1";
            check_eq({p, ".o_valid"}, 64'(ob_ov[d]), 64'(m_held[d]));
            check_eq({p, ".o_last"},  64'(ob_last[d]), 64'(m_held[d] && (m_k[d] == npix[d] - 1)));
            check_eq({p, ".i_ready"}, 64'(ob_ir[d]), 64'(exp_ir(d)));
            if (m_held[d] || m_fresh[d]) begin
                check_eq({p, ".o_row"},  64'(ob_row[d]), 64'(m_k[d] / img_w[d]));
                check_eq({p, ".o_col"},  64'(ob_col[d]), 64'(m_k[d] % img_w[d]));
                check_eq({p, ".o_data"}, 64'(ob_dat[d]), 64'(m_vec[d]));
            end
        end
    endtask

    task automatic drive_rand(input int d, input int pv, input int pr);
        if (!m_pend[d]) begin
            iv[d]   = (int'($urandom_range(0, 99)) < pv);
            idat[d] = {$urandom, $urandom};
        end
        ordy[d] = (int'($urandom_range(0, 99)) < pr);
    endtask

    task automatic cycle();
        bit acc  [2];
        bit beat [2];
        if (cont1) begin
            iv[1]   = 1'b1;
            ordy[1] = 1'b1;
            if (!m_pend[1]) idat[1] = {$urandom, $urandom};
        end
        #1;
        check_all();
        for (int d = 0; d < 2; d++) begin
            acc[d]  = (iv[d] === 1'b1) && exp_ir(d);
            beat[d] = m_held[d] && (ordy[d] === 1'b1);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_held[d]  = 1'b0;
                m_k[d]     = 0;
                m_vec[d]   = '0;
                m_fresh[d] = 1'b1;
                m_pend[d]  = 1'b0;
            end else begin
                m_pend[d] = iv[d] && !acc[d];
                if (acc[d]) m_accs[d]++;
                if (beat[d]) m_beats[d]++;
                if (beat[d] && (m_k[d] == npix[d] - 1)) begin
                    m_k[d] = 0;
                    if (acc[d]) begin
                        m_vec[d]   = idat[d];
                        m_fresh[d] = 1'b0;
                    end else begin
                        m_held[d] = 1'b0;
                    end
                end else if (beat[d]) begin
                    m_k[d]++;
                end else if (acc[d]) begin
                    m_vec[d]   = idat[d];
                    m_k[d]     = 0;
                    m_held[d]  = 1'b1;
                    m_fresh[d] = 1'b0;
                end
            end
        end
        #1;
    endtask

    localparam logic [VW-1:0] VEC_T = 64'h807F01FF_00102030;
    localparam logic [VW-1:0] VEC_A = {8{8'h11}};
    localparam logic [VW-1:0] VEC_B = {8{8'h22}};
    localparam logic [VW-1:0] VEC_C = 64'hC3A5_807F_0001_FFEE;

    initial begin
        int base;
        int base1;
        int at;
        n_checks = 0;
        n_fail   = 0;
        cont1    = 1'b0;
        rst      = 1'b1;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; idat[d] = '0;
            m_held[d] = 1'b0; m_k[d] = 0; m_vec[d] = '0; m_fresh[d] = 1'b1;
            m_pend[d] = 1'b0; m_beats[d] = 0; m_accs[d] = 0;
        end
        @(posedge clk);
        #1;
        cycle();
        rst   = 1'b0;
        cont1 = 1'b1;

        // Single vector, downstream always ready.
        base  = m_beats[0];
        base1 = m_accs[1];
        iv[0] = 1'b1; idat[0] = VEC_T; ordy[0] = 1'b1;
        cycle();
        iv[0] = 1'b0;
        repeat (22) cycle();
        check_eq("p1_beats", 64'(m_beats[0] - base), 64'd20);
        check_eq("u1x1_vec_per_cycle", 64'(m_accs[1] - base1), 64'd23);

        // Same vector under random backpressure.
        base  = m_beats[0];
        iv[0] = 1'b1;
        cycle();
        iv[0] = 1'b0;
        for (int i = 0; i < 60; i++) begin
            ordy[0] = 1'($urandom_range(0, 1));
            cycle();
        end
        ordy[0] = 1'b1;
        repeat (21) cycle();
        check_eq("p2_beats", 64'(m_beats[0] - base), 64'd20);

        // Back-to-back vectors without a bubble.
        base  = m_beats[0];
        iv[0] = 1'b1; idat[0] = VEC_A;
        cycle();
        idat[0] = VEC_B;
        at = -1;
        for (int i = 0; i < 25; i++) begin
            cycle();
            if (!m_pend[0]) begin at = i; break; end
        end
        iv[0] = 1'b0;
        check_eq("b2b_accept_slot", 64'(at), 64'd19);
        repeat (21) cycle();
        check_eq("b2b_beats", 64'(m_beats[0] - base), 64'd40);

        // Vector offered mid-raster must wait for the last beat.
        iv[0] = 1'b1; idat[0] = VEC_A;
        cycle();
        iv[0] = 1'b0;
        repeat (4) cycle();
        iv[0] = 1'b1; idat[0] = VEC_C;
        at = -1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (!m_pend[0]) begin at = i; break; end
        end
        iv[0] = 1'b0;
        check_eq("c_wait_slot", 64'(at), 64'd15);
        repeat (21) cycle();

        // Reset in the middle of a raster.
        iv[0] = 1'b1; idat[0] = VEC_A;
        cycle();
        iv[0] = 1'b0;
        repeat (6) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        base  = m_beats[0];
        iv[0] = 1'b1; idat[0] = VEC_B;
        cycle();
        iv[0] = 1'b0;
        repeat (21) cycle();
        check_eq("post_rst_beats", 64'(m_beats[0] - base), 64'd20);

        // Random traffic on both instances.
        cont1 = 1'b0;
        for (int i = 0; i < 800; i++) begin
            drive_rand(0, 40, 70);
            drive_rand(1, 50, 60);
            cycle();
        end
        for (int i = 0; i < 30; i++) begin
            for (int d = 0; d < 2; d++) begin
                if (!m_pend[d]) iv[d] = 1'b0;
                ordy[d] = 1'b1;
            end
            cycle();
        end
        check_eq("u4x5_drained", 64'(m_held[0]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/global_broadcast_unit.md
Name: global_broadcast_unit

Overview:
- Inverse of global average pooling: accepts one IN_CH-channel vector and replays it as a full IMG_H x IMG_W raster of pixels, one pixel per output beat.
- Feeds per-channel global values back to feature-map resolution, e.g. excitation scaling or global-context concat.
- Valid/ready handshake on both sides; holds one vector; no bubble between consecutive vectors.

Parameters:
- DATA_W, 8, bits per channel element (signed).
- IN_CH, 8, channels per vector/pixel.
- IMG_H, 4, output raster rows (>=1).
- IMG_W, 5, output raster columns (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  input vector valid.
- i_ready  out  1  unit can accept a vector this cycle.
- i_data_flat  in  IN_CH*DATA_W  signed input vector; channel k at bits [(k+1)*DATA_W-1 : k*DATA_W].
- o_valid  out  1  output pixel valid.
- o_ready  in  1  downstream accepts pixel.
- o_data_flat  out  IN_CH*DATA_W  output pixel, same packing as input.
- o_row  out  RW=max(1,$clog2(IMG_H))  row index of current pixel.
- o_col  out  CW=max(1,$clog2(IMG_W))  column index of current pixel.
- o_last  out  1  high on final pixel (row IMG_H-1, col IMG_W-1).

Behaviour:
- Reset (rst=1 at a clock edge): state=S_IDLE, o_valid=0, o_data_flat=0, o_row=0, o_col=0, o_last=0. Reset overrides all other events. Reset mid-raster abandons the held vector; no further beats.
- States: S_IDLE (empty), S_EMIT (vector held, streaming).
- i_ready = (state==S_IDLE) || (state==S_EMIT && o_last && o_ready). Combinational path o_ready->i_ready is permitted and intended.
- Accept = i_valid && i_ready.
- S_IDLE: on accept: o_data_flat <= i_data_flat, o_row <= 0, o_col <= 0, o_last <= (PIXEL_COUNT==1), o_valid <= 1, go S_EMIT. Latency: vector accepted at edge N gives o_valid=1 from cycle N+1.
- S_EMIT, beat fires (o_valid && o_ready):
  - Not last: col+1; at col==IMG_W-1, col<=0 and row+1. o_last <= 1 when the next position is (IMG_H-1, IMG_W-1). o_data_flat unchanged.
  - Last with simultaneous accept: load the new vector exactly as in S_IDLE and stay in S_EMIT. No bubble.
  - Last without accept: o_valid <= 0, o_last <= 0, go S_IDLE.
- S_EMIT, o_ready=0: all outputs hold stable (AXI-style; valid never drops without a handshake).
- i_valid while S_EMIT and not on a last-beat handshake: i_ready=0, input ignored; upstream holds.
- Data is a pure copy with no arithmetic; sign and bit pattern are preserved exactly.
- Throughput: exactly PIXEL_COUNT=IMG_H*IMG_W output beats per accepted vector. Continuous input and o_ready give one beat per cycle.
- Raster order is row-major: col increments fastest.
- Degenerate case IMG_H=IMG_W=1: every beat has o_last=1, row=col=0, and i_ready tracks o_ready while emitting.
- Illegal state encoding returns to S_IDLE with o_valid=0.

Decomposition:
- Shared package cnn_pool_pkg: PIXEL_COUNT(h,w) function, clog2-with-floor-1 width function, state encodings S_IDLE/S_EMIT, and the channel pack/unpack slice convention. global_avg_pool_unit and this block share it.
- One sub-module, raster_counter: inputs clk, rst, load, step; outputs row, col, last; parameters IMG_H, IMG_W. Reused by future spatial stream blocks.
- Top module keeps the FSM, data hold register and handshake logic.

Test Plan:
- Single vector 0x807F01FF_00102030, o_ready=1 -> 20 beats on consecutive cycles, data identical each beat, (row,col) (0,0),(0,1)..(0,4),(1,0)..(3,4), o_last only on beat 20, o_valid=0 on cycle 21, i_ready=1 again.
- Same vector with o_ready toggling on a pseudo-random pattern -> still exactly 20 handshakes. While stalled, o_data_flat, o_row, o_col and o_last hold stable. No index skipped or repeated.
- Back-to-back vectors A=0x11..., B=0x22..., i_valid held, o_ready=1 -> beat 20 of A is immediately followed by beat 1 of B (row 0, col 0). i_ready is high only on A's last-beat cycle. 40 beats in 40 cycles.
- i_valid asserted with vector C at A's beat 5 -> i_ready=0 until A's last beat. C appears only after A's 20 beats and is not corrupted.
- rst=1 at A's beat 7 -> next cycle o_valid=0, o_row=o_col=0, o_last=0, i_ready=1. Next vector starts fresh at (0,0) with 20 beats.
- Build with IMG_H=1, IMG_W=1 -> each accepted vector produces one beat with o_last=1. Continuous i_valid/o_ready gives one vector per cycle.
